mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle control state machine for the MIPS CPU: sequences a single shared ALU, a single unified memory port, the IR and the PC across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It replaces the per-instruction combinational decode of the single-cycle core. Control outputs are Moore outputs decoded from the state register, plus the instruction opcode/funct. Memory accesses use a variable-latency req/ack handshake.

## Interface
- TIMEOUT, 16: memory-ack watchdog limit in cycles (used only with MC_MEM_TIMEOUT_EN).
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- opcode_i  in  6  IR[31:26], valid from DECODE onward.
- funct_i  in  6  IR[5:0].
- zero_i  in  1  ALU result == 0.
- neg_i  in  1  ALU result[31].
- mem_ack_i  in  1  memory completed current request.
- mem_req_o  out  1  memory request, held until ack.
- mem_we_o  out  1  write when mem_req_o=1.
- i_or_d_o  out  1  0=PC address, 1=ALUOut address.
- ir_write_o / pc_write_o  out  1 each  IR / PC load strobes.
- alu_src_a_o  out  1  0=PC, 1=rs.
- alu_src_b_o  out  2  00=rt, 01=4, 10=sign-ext imm, 11=imm<<2.
- alu_op_o  out  3  same encoding as single-cycle core (010 R, 001 sub-compare, 100 add, 101 slti, 011 lui, 000 ori, 110 zero/sign test, 111 jal).
- reg_write_o  out  1; reg_dst_o  out  2 (0=rt, 1=rd, 2=$31); mem_to_reg_o  out  2 (0=ALUOut, 1=MDR, 2=PC).
- pc_source_o  out  2  0=ALU, 1=ALUOut, 2=jump target, 3=rs (jr).
- illegal_o  out  1  one-cycle pulse on unsupported opcode.
- err_o  out  1  sticky watchdog error (MC_MEM_TIMEOUT_EN only, else tied 0).

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, ERR.
- IDLE → FETCH unconditionally on first clock after reset release.
- FETCH: mem_req_o=1, i_or_d_o=0, alu PC+4 (a=0, b=01, op=100). Wait until mem_ack_i=1; that cycle ir_write_o=pc_write_o=1, pc_source_o=0, go DECODE.
- DECODE: ALUOut ← PC+(imm<<2) (b=11, op=100). Dispatch: op 0 → EXEC_R (funct 8 = jr → JUMP with pc_source 3); 8,10,13,15 → EXEC_I; 35,43 → MEM_ADDR; 4,5,7,6,1 → BRANCH; 2 → JUMP; 3 → JAL; other → illegal_o=1, FETCH.
- EXEC_R→WB_R (reg_dst 1); EXEC_I→WB_I (reg_dst 0), alu_op per opcode as listed.
- MEM_ADDR (a=1, b=10, op=100) → MEM_RD (lw) or MEM_WR (sw). MEM_RD: req, i_or_d=1, on ack → WB_MEM (mem_to_reg 1). MEM_WR: req+we, on ack → FETCH.
- BRANCH: a=1, b=00; pc_write_o=taken, pc_source_o=1. taken: beq zero; bne !zero; bgt !zero&!neg; bnez !zero; bgez !neg. → FETCH.
- JUMP: pc_write_o=1, pc_source 2 (or 3 for jr). JAL: pc_write_o=1, pc_source 2, reg_write_o=1, reg_dst 2, mem_to_reg 2 (old PC+4). → FETCH.
- All WB states assert reg_write_o for exactly one cycle → FETCH.

## Timing
- Reset: state=IDLE, every output 0 immediately (asynchronous), including a mem_req_o in flight.
- Zero-wait memory (ack same cycle as req): R/I 4 cycles, lw 5, sw 4, branch/j/jal/jr 3. Each wait cycle adds one.
- mem_req_o and mem_we_o stable from assertion until the ack cycle inclusive; deasserted the following cycle. mem_ack_i outside FETCH/MEM_RD/MEM_WR ignored.
- illegal_o asserted only in the DECODE cycle.

## Configuration
- MC_MEM_TIMEOUT_EN defined: counter counts cycles with mem_req_o=1 and no ack; reaching TIMEOUT → ERR, err_o=1, all strobes 0, stays until reset. Counter clears on ack.
- Undefined: no counter, ERR unreachable, err_o constant 0; wait indefinitely.

## Structure
- Package mc_ctrl_pkg: state enum, opcode/funct constants, alu_op codes, alu_src_b / pc_source / reg_dst / mem_to_reg encodings.
- Sub-module mc_branch_eval: combinational taken decision from opcode_i, zero_i, neg_i.

## Test plan
- Reset mid-FETCH with mem_req_o=1 → all outputs 0 in same cycle; IDLE then FETCH after release.
- add (op 0, funct 32), ack immediate → 4 cycles, reg_write_o high only in WB_R, reg_dst_o=1.
- lw (op 35), fetch ack after 2 waits, data ack after 3 waits → 10 cycles total; mem_req_o held through waits; mem_to_reg_o=1 at WB.
- bgt (op 7) zero_i=0 neg_i=0 → pc_write_o=1, pc_source_o=1; neg_i=1 → pc_write_o=0; 3 cycles each.
- jal (op 3) → reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2, pc_source_o=2; opcode 63 → illegal_o pulse, back to FETCH.
- With MC_MEM_TIMEOUT_EN, TIMEOUT=16, ack withheld → ERR after 16 request cycles, err_o=1 until reset.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// Opcode/funct constants, ALU op codes and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
      WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, ERR
   } stateT;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BGEZ  = 6'd1;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_BNEZ  = 6'd6;
   localparam logic [5:0] OP_BGT   = 6'd7;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] FN_JR    = 6'd8;

   localparam logic [2:0] ALU_ORI  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_R    = 3'b010;
   localparam logic [2:0] ALU_LUI  = 3'b011;
   localparam logic [2:0] ALU_ADD  = 3'b100;
   localparam logic [2:0] ALU_SLTI = 3'b101;
   localparam logic [2:0] ALU_TEST = 3'b110;
   localparam logic [2:0] ALU_JAL  = 3'b111;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_RS     = 2'd3;

   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   function automatic logic [2:0] iTypeAluOp(input logic [5:0] opcode);
      case (opcode)
         OP_SLTI: return ALU_SLTI;
         OP_ORI:  return ALU_ORI;
         OP_LUI:  return ALU_LUI;
         default: return ALU_ADD;
      endcase
   endfunction

   // Two-register compares subtract; single-register tests use the sign/zero test.
   function automatic logic [2:0] branchAluOp(input logic [5:0] opcode);
      case (opcode)
         OP_BNEZ, OP_BGEZ: return ALU_TEST;
         default:          return ALU_SUB;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Unified memory port handshake between the control FSM and memory.
// The FSM holds mem_req_o/mem_we_o until mem_ack_i.
interface mc_ctrl_fsm_if;
   logic mem_req_o;
   logic mem_we_o;
   logic i_or_d_o;
   logic mem_ack_i;

   modport master (output mem_req_o, output mem_we_o, output i_or_d_o, input mem_ack_i);
   modport slave  (input mem_req_o, input mem_we_o, input i_or_d_o, output mem_ack_i);
endinterface

// File: rtl/mc_branch_eval.sv
// Combinational branch-taken decision from opcode and ALU flags.
module mc_branch_eval
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic       zero_i,
   input  logic       neg_i,
   output logic       taken_o
);

   always_comb begin
      case (opcode_i)
         OP_BEQ:  taken_o = zero_i;
         OP_BNE:  taken_o = !zero_i;
         OP_BGT:  taken_o = !zero_i && !neg_i;
         OP_BNEZ: taken_o = !zero_i;
         OP_BGEZ: taken_o = !neg_i;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences ALU, memory port, IR and PC.
// Define MC_MEM_TIMEOUT_EN to enable the memory-ack watchdog (ERR state, err_o).
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   mc_ctrl_fsm_if.master     memBus,
   input  logic [5:0]        opcode_i,
   input  logic [5:0]        funct_i,
   input  logic              zero_i,
   input  logic              neg_i,
   output logic              ir_write_o,
   output logic              pc_write_o,
   output logic              alu_src_a_o,
   output logic [1:0]        alu_src_b_o,
   output logic [2:0]        alu_op_o,
   output logic              reg_write_o,
   output logic [1:0]        reg_dst_o,
   output logic [1:0]        mem_to_reg_o,
   output logic [1:0]        pc_source_o,
   output logic              illegal_o,
   output logic              err_o
);

   if (TIMEOUT < 2) begin : gBadTimeout
      $error("TIMEOUT must be at least 2");
   end

   stateT state, nextState;
   logic  memReq, memWe, iOrD;
   logic  branchTaken;
   logic  isJr;
   logic  memAck;

   assign memAck = memBus.mem_ack_i;
   assign isJr   = (opcode_i == OP_RTYPE) && (funct_i == FN_JR);

   mc_branch_eval uBranchEval (
      .opcode_i (opcode_i),
      .zero_i   (zero_i),
      .neg_i    (neg_i),
      .taken_o  (branchTaken)
   );

`ifdef MC_MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] waitCnt;
   logic             timeoutHit;

   assign timeoutHit = memReq && !memAck && (waitCnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                 waitCnt <= '0;
      else if (memReq && !memAck) waitCnt <= waitCnt + 1'b1;
      else                        waitCnt <= '0;
   end

   assign err_o = (state == ERR);
`else
   assign err_o = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      nextState    = state;
      memReq       = 1'b0;
      memWe        = 1'b0;
      iOrD         = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = SRCB_RT;
      alu_op_o     = ALU_ORI;
      reg_write_o  = 1'b0;
      reg_dst_o    = REGDST_RT;
      mem_to_reg_o = M2R_ALUOUT;
      pc_source_o  = PCSRC_ALU;
      illegal_o    = 1'b0;

      case (state)
         IDLE: nextState = FETCH;
         FETCH: begin
            memReq      = 1'b1;
            alu_src_b_o = SRCB_FOUR;
            alu_op_o    = ALU_ADD;
            if (memAck) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               nextState  = DECODE;
            end
         end
         DECODE: begin
            alu_src_b_o = SRCB_BRANCH;
            alu_op_o    = ALU_ADD;
            case (opcode_i)
               OP_RTYPE:                          nextState = isJr ? JUMP : EXEC_R;
               OP_ADDI, OP_SLTI, OP_ORI, OP_LUI:  nextState = EXEC_I;
               OP_LW, OP_SW:                      nextState = MEM_ADDR;
               OP_BEQ, OP_BNE, OP_BGT, OP_BNEZ,
               OP_BGEZ:                           nextState = BRANCH;
               OP_J:                              nextState = JUMP;
               OP_JAL:                            nextState = JAL;
               default: begin
                  illegal_o = 1'b1;
                  nextState = FETCH;
               end
            endcase
         end
         EXEC_R: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALU_R;
            nextState   = WB_R;
         end
         EXEC_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = iTypeAluOp(opcode_i);
            nextState   = WB_I;
         end
         MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALU_ADD;
            nextState   = (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            memReq = 1'b1;
            iOrD   = 1'b1;
            if (memAck) nextState = WB_MEM;
         end
         MEM_WR: begin
            memReq = 1'b1;
            memWe  = 1'b1;
            iOrD   = 1'b1;
            if (memAck) nextState = FETCH;
         end
         WB_R: begin
            reg_write_o = 1'b1;
            reg_dst_o   = REGDST_RD;
            nextState   = FETCH;
         end
         WB_I: begin
            reg_write_o = 1'b1;
            nextState   = FETCH;
         end
         WB_MEM: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = M2R_MDR;
            nextState    = FETCH;
         end
         BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = branchAluOp(opcode_i);
            pc_write_o  = branchTaken;
            pc_source_o = PCSRC_ALUOUT;
            nextState   = FETCH;
         end
         JUMP: begin
            pc_write_o  = 1'b1;
            pc_source_o = isJr ? PCSRC_RS : PCSRC_JUMP;
            nextState   = FETCH;
         end
         JAL: begin
            pc_write_o   = 1'b1;
            pc_source_o  = PCSRC_JUMP;
            alu_op_o     = ALU_JAL;
            reg_write_o  = 1'b1;
            reg_dst_o    = REGDST_RA;
            mem_to_reg_o = M2R_PC;
            nextState    = FETCH;
         end
         ERR:     nextState = ERR;
         default: nextState = IDLE;
      endcase

`ifdef MC_MEM_TIMEOUT_EN
      if (timeoutHit) nextState = ERR;
`endif
   end

   assign memBus.mem_req_o = memReq;
   assign memBus.mem_we_o  = memWe;
   assign memBus.i_or_d_o  = iOrD;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: table of instructions with per-run
// expectations, plus reset and memory-watchdog sequences.
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rstN;
   logic [5:0] opcode, funct;
   logic       zero, neg;
   logic       irWrite, pcWrite, aluSrcA, regWrite, illegal, err;
   logic [1:0] aluSrcB, regDst, memToReg, pcSource;
   logic [2:0] aluOp;

   int nChecks = 0;
   int nFails  = 0;

   mc_ctrl_fsm_if memBus ();

   mc_ctrl_fsm #(.TIMEOUT(16)) dut (
      .clk_i        (clk),
      .rst_i        (rstN),
      .memBus       (memBus),
      .opcode_i     (opcode),
      .funct_i      (funct),
      .zero_i       (zero),
      .neg_i        (neg),
      .ir_write_o   (irWrite),
      .pc_write_o   (pcWrite),
      .alu_src_a_o  (aluSrcA),
      .alu_src_b_o  (aluSrcB),
      .alu_op_o     (aluOp),
      .reg_write_o  (regWrite),
      .reg_dst_o    (regDst),
      .mem_to_reg_o (memToReg),
      .pc_source_o  (pcSource),
      .illegal_o    (illegal),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   wire [19:0] allOuts = {memBus.mem_req_o, memBus.mem_we_o, memBus.i_or_d_o, irWrite,
                          pcWrite, aluSrcA, aluSrcB, aluOp, regWrite, regDst, memToReg,
                          pcSource, illegal, err};
   wire inFetch = memBus.mem_req_o && !memBus.i_or_d_o;

   typedef struct {
      string      name;
      logic [5:0] op, fn;
      logic       z, n, ackIdle;
      int         fw, dw;
      int         cycles, regWrites, illegals, pcWrites, wes;
      logic [1:0] pcSrc, regDst, memToReg;
   } vecT;

   vecT vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction starting in a FETCH cycle and ending at the next FETCH.
   task automatic runVec(input vecT v);
      int cyc = 0, fwc = 0, dwc = 0, rw = 0, ill = 0, pcw = 0, we = 0;
      bit left = 0, done = 0;
      logic [1:0] lastPcSrc = 0, lastRegDst = 0, lastM2r = 0;
      opcode = v.op; funct = v.fn; zero = v.z; neg = v.n;
      while (!done && cyc < 40) begin
         if (inFetch) begin
            memBus.mem_ack_i = (fwc == v.fw); fwc++;
         end else if (memBus.mem_req_o) begin
            memBus.mem_ack_i = (dwc == v.dw); dwc++;
         end else begin
            memBus.mem_ack_i = v.ackIdle;
         end
         #1;
         rw  += int'(regWrite);
         ill += int'(illegal);
         pcw += int'(pcWrite);
         we  += int'(memBus.mem_req_o && memBus.mem_we_o);
         lastPcSrc = pcSource; lastRegDst = regDst; lastM2r = memToReg;
         cyc++;
         if (!inFetch) left = 1;
         stepCycle();
         if (left && inFetch) done = 1;
      end
      memBus.mem_ack_i = 1'b0;
      check({v.name, " done"}, 32'(done), 32'd1);
      check({v.name, " cycles"}, cyc, v.cycles);
      check({v.name, " reg_write cycles"}, rw, v.regWrites);
      check({v.name, " illegal pulses"}, ill, v.illegals);
      check({v.name, " pc_write cycles"}, pcw, v.pcWrites);
      check({v.name, " mem_we cycles"}, we, v.wes);
      check({v.name, " pc_source"}, 32'(lastPcSrc), 32'(v.pcSrc));
      check({v.name, " reg_dst"}, 32'(lastRegDst), 32'(v.regDst));
      check({v.name, " mem_to_reg"}, 32'(lastM2r), 32'(v.memToReg));
   endtask

   task automatic resetAndRestart();
      rstN = 1'b0;
      #1;
      check("async reset outputs", 32'(allOuts), 32'd0);
      stepCycle();
      rstN = 1'b1;
      #1;
      check("idle after release", 32'(allOuts), 32'd0);
      stepCycle();
      check("fetch req", 32'(memBus.mem_req_o), 32'd1);
      check("fetch alu", {29'd0, aluOp}, 32'b100);
      check("fetch srcb", 32'(aluSrcB), 32'b01);
      check("fetch i_or_d", 32'(memBus.i_or_d_o), 32'd0);
   endtask

   initial begin
      //          name    op  fn  z  n ai fw dw cyc rw il pcw we src dst m2r
      vecs[0]  = '{"add",  0, 32, 0, 0, 1, 0, 0, 4,  1, 0, 1, 0, 0, 1, 0};
      vecs[1]  = '{"lw",   35, 0, 0, 0, 0, 2, 3, 10, 1, 0, 1, 0, 0, 0, 1};
      vecs[2]  = '{"sw",   43, 0, 0, 0, 0, 1, 2, 7,  0, 0, 1, 3, 0, 0, 0};
      vecs[3]  = '{"addi", 8,  0, 0, 0, 0, 0, 0, 4,  1, 0, 1, 0, 0, 0, 0};
      vecs[4]  = '{"beqT", 4,  0, 1, 0, 0, 0, 0, 3,  0, 0, 2, 0, 1, 0, 0};
      vecs[5]  = '{"bneN", 5,  0, 1, 0, 0, 0, 0, 3,  0, 0, 1, 0, 1, 0, 0};
      vecs[6]  = '{"bgtT", 7,  0, 0, 0, 0, 0, 0, 3,  0, 0, 2, 0, 1, 0, 0};
      vecs[7]  = '{"bgtN", 7,  0, 0, 1, 0, 0, 0, 3,  0, 0, 1, 0, 1, 0, 0};
      vecs[8]  = '{"bnezT",6,  0, 0, 0, 0, 0, 0, 3,  0, 0, 2, 0, 1, 0, 0};
      vecs[9]  = '{"bgezN",1,  0, 0, 1, 0, 0, 0, 3,  0, 0, 1, 0, 1, 0, 0};
      vecs[10] = '{"j",    2,  0, 0, 0, 1, 0, 0, 3,  0, 0, 2, 0, 2, 0, 0};
      vecs[11] = '{"jr",   0,  8, 0, 0, 0, 0, 0, 3,  0, 0, 2, 0, 3, 0, 0};
      vecs[12] = '{"jal",  3,  0, 0, 0, 0, 0, 0, 3,  1, 0, 2, 0, 2, 2, 2};
      vecs[13] = '{"ill63",63, 0, 0, 0, 0, 0, 0, 2,  0, 1, 1, 0, 0, 0, 0};

      opcode = 0; funct = 0; zero = 0; neg = 0;
      memBus.mem_ack_i = 1'b0;
      resetAndRestart();

      // Reset while a fetch request is outstanding.
      repeat (2) stepCycle();
      check("req held while waiting", 32'(memBus.mem_req_o), 32'd1);
      #2;
      resetAndRestart();

      foreach (vecs[i]) runVec(vecs[i]);

`ifdef MC_MEM_TIMEOUT_EN
      begin
         int reqCycles = 0;
         memBus.mem_ack_i = 1'b0;
         while (memBus.mem_req_o && !err && reqCycles < 40) begin
            reqCycles++;
            stepCycle();
         end
         check("timeout request cycles", reqCycles, 16);
         check("err set", 32'(err), 32'd1);
         check("err outputs", 32'(allOuts), 32'd1);
         repeat (3) stepCycle();
         memBus.mem_ack_i = 1'b1;
         #1;
         check("err sticky", 32'(allOuts), 32'd1);
         memBus.mem_ack_i = 1'b0;
      end
`else
      memBus.mem_ack_i = 1'b0;
      repeat (30) stepCycle();
      check("no watchdog req held", 32'(memBus.mem_req_o), 32'd1);
      check("no watchdog err", 32'(err), 32'd0);
`endif
      resetAndRestart();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
